// File: rtl/mul_hilo_seq_pkg.sv
// Shared constants and state encoding for the multiply sequencer and its
// HI/LO result register pair.
package mul_hilo_seq_pkg;

  localparam int DEF_WORD_W = 32;
  // Wide enough for the largest legal settle count (15).
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

endpackage

// File: rtl/mul_hilo_seq_if.sv
// Control-unit facing bus of the multiply sequencer: operand request,
// multiplier drive/return, HI/LO direct writes and the busy/done handshake.
interface mul_hilo_seq_if #(
  parameter int WORD_W = mul_hilo_seq_pkg::DEF_WORD_W
);

  logic                  start;
  logic [WORD_W-1:0]     op_a;
  logic [WORD_W-1:0]     op_b;
  logic [WORD_W-1:0]     mul_m;
  logic [WORD_W-1:0]     mul_q;
  logic [2*WORD_W-1:0]   prod_in;
  logic                  hi_wr;
  logic [WORD_W-1:0]     hi_din;
  logic                  lo_wr;
  logic [WORD_W-1:0]     lo_din;
  logic [WORD_W-1:0]     hi_out;
  logic [WORD_W-1:0]     lo_out;
  logic                  busy;
  logic                  done;

  // master: control unit plus the external multiplier returning prod_in
  modport master (
    output start, op_a, op_b, prod_in, hi_wr, hi_din, lo_wr, lo_din,
    input  mul_m, mul_q, hi_out, lo_out, busy, done
  );

  modport slave (
    input  start, op_a, op_b, prod_in, hi_wr, hi_din, lo_wr, lo_din,
    output mul_m, mul_q, hi_out, lo_out, busy, done
  );

endinterface

// File: rtl/mul_hilo_seq_hilo_reg.sv
// HI/LO register pair: each half takes its direct write if enabled, otherwise
// the matching half of the product on a capture edge.
module hilo_reg
  import mul_hilo_seq_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                capture,
  input  logic [2*WORD_W-1:0] prod,
  input  logic                hi_wr,
  input  logic [WORD_W-1:0]   hi_din,
  input  logic                lo_wr,
  input  logic [WORD_W-1:0]   lo_din,
  output logic [WORD_W-1:0]   hi_out,
  output logic [WORD_W-1:0]   lo_out
);

  logic [1:0]             wr_vec;
  logic [1:0][WORD_W-1:0] din_vec;
  logic [1:0][WORD_W-1:0] cap_vec;
  logic [1:0][WORD_W-1:0] half_vec;

  // Index 1 is HI, index 0 is LO throughout.
  assign wr_vec  = {hi_wr, lo_wr};
  assign din_vec = {hi_din, lo_din};
  assign cap_vec = prod;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      logic [WORD_W-1:0] half_reg;

      // A direct write issued on the capture edge wins over the product.
      always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
          half_reg <= '0;
        end else if (wr_vec[gi]) begin
          half_reg <= din_vec[gi];
        end else if (capture) begin
          half_reg <= cap_vec[gi];
        end
      end

      assign half_vec[gi] = half_reg;
    end
  endgenerate

  assign hi_out = half_vec[1];
  assign lo_out = half_vec[0];

endmodule

// File: rtl/mul_hilo_seq.sv
// Multiply sequencer: latches operands for the external combinational
// multiplier, waits SETTLE_CYCLES edges, then captures the product into HI/LO.
module mul_hilo_seq
  import mul_hilo_seq_pkg::*;
#(
  parameter int WORD_W        = DEF_WORD_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clock,
  input  logic           clear,
  mul_hilo_seq_if.slave  bus
);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WORD_W-1:0]  mul_m_reg;
  logic [WORD_W-1:0]  mul_q_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               capture;

  assign capture = (state_reg == ST_SETTLE) && (cnt_reg == CNT_W'(1));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      mul_m_reg <= '0;
      mul_q_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            mul_m_reg <= bus.op_a;
            mul_q_reg <= bus.op_b;
            cnt_reg   <= CNT_W'(SETTLE_CYCLES);
            busy_reg  <= 1'b1;
            state_reg <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // start is deliberately ignored here; operands stay frozen.
          if (cnt_reg == CNT_W'(1)) begin
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  hilo_reg #(
    .WORD_W (WORD_W)
  ) u_hilo_reg (
    .clock   (clock),
    .clear   (clear),
    .capture (capture),
    .prod    (bus.prod_in),
    .hi_wr   (bus.hi_wr),
    .hi_din  (bus.hi_din),
    .lo_wr   (bus.lo_wr),
    .lo_din  (bus.lo_din),
    .hi_out  (bus.hi_out),
    .lo_out  (bus.lo_out)
  );

  assign bus.mul_m = mul_m_reg;
  assign bus.mul_q = mul_q_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_mul_hilo_seq.sv
// Directed bench for mul_hilo_seq: one instance with SETTLE_CYCLES=2, one with 1,
// each closed through a behavioural signed 32x32 multiplier.
module tb_mul_hilo_seq;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clock = ~clock;

  mul_hilo_seq_if #(.WORD_W(32)) bus2 ();
  mul_hilo_seq_if #(.WORD_W(32)) bus1 ();

  mul_hilo_seq #(.WORD_W(32), .SETTLE_CYCLES(2)) dut2 (
    .clock (clock),
    .clear (clear),
    .bus   (bus2.slave)
  );

  mul_hilo_seq #(.WORD_W(32), .SETTLE_CYCLES(1)) dut1 (
    .clock (clock),
    .clear (clear),
    .bus   (bus1.slave)
  );

  // Low 64 bits of the product of sign-extended operands = signed product.
  assign bus2.prod_in = $signed({{32{bus2.mul_m[31]}}, bus2.mul_m}) *
                        $signed({{32{bus2.mul_q[31]}}, bus2.mul_q});
  assign bus1.prod_in = $signed({{32{bus1.mul_m[31]}}, bus1.mul_m}) *
                        $signed({{32{bus1.mul_q[31]}}, bus1.mul_q});

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one multiply on the SETTLE_CYCLES=2 instance and watch 8 cycles.
  task automatic run_mul2(input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_n, output int done_at,
                          output logic [31:0] hi, output logic [31:0] lo);
    bus2.start = 1'b1;
    bus2.op_a  = a;
    bus2.op_b  = b;
    tick();
    bus2.start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; hi = 'x; lo = 'x;
    for (int i = 0; i < 8; i++) begin
      if (bus2.busy) busy_n++;
      if (bus2.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
        hi = bus2.hi_out;
        lo = bus2.lo_out;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus2.start = 0; bus2.op_a = 0; bus2.op_b = 0;
    bus2.hi_wr = 0; bus2.hi_din = 0; bus2.lo_wr = 0; bus2.lo_din = 0;
    bus1.start = 0; bus1.op_a = 0; bus1.op_b = 0;
    bus1.hi_wr = 0; bus1.hi_din = 0; bus1.lo_wr = 0; bus1.lo_din = 0;
    clear = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus2.hi_out, bus2.lo_out} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo: got %h expected 0", {bus2.hi_out, bus2.lo_out});
    end
    vectors++;
    if ({bus2.mul_m, bus2.mul_q} !== 64'h0) begin
      errors++; $display("FAIL reset_mul_mq: got %h expected 0", {bus2.mul_m, bus2.mul_q});
    end
    vectors++;
    if ({bus2.busy, bus2.done, bus1.busy, bus1.done} !== 4'b0) begin
      errors++; $display("FAIL reset_busy_done: got %b expected 0000",
                         {bus2.busy, bus2.done, bus1.busy, bus1.done});
    end
    clear = 1'b1;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    int bn, dn, da;
    logic [31:0] hi, lo;
    run_mul2(32'd7, 32'hFFFFFFFD, bn, dn, da, hi, lo);
    vectors++;
    if (bn !== 2) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 2", bn); end
    vectors++;
    if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", dn); end
    vectors++;
    if (da !== 2) begin errors++; $display("FAIL basic_done_edge: got E+%0d expected E+2", da); end
    vectors++;
    if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL basic_hi: got %h expected ffffffff", hi); end
    vectors++;
    if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL basic_lo: got %h expected ffffffeb", lo); end
    vectors++;
    if (bus2.mul_m !== 32'd7) begin
      errors++; $display("FAIL basic_mul_m_hold: got %h expected 00000007", bus2.mul_m);
    end
    $display("test_basic: 7 * -3 -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_extremes();
    int bn, dn, da;
    logic [31:0] hi, lo;
    run_mul2(32'h80000000, 32'h80000000, bn, dn, da, hi, lo);
    vectors++;
    if ({hi, lo} !== 64'h40000000_00000000) begin
      errors++; $display("FAIL ext_minmin: got %h_%h expected 40000000_00000000", hi, lo);
    end
    $display("test_extremes: min*min -> hi=%h lo=%h", hi, lo);
    run_mul2(32'h7FFFFFFF, 32'hFFFFFFFF, bn, dn, da, hi, lo);
    vectors++;
    if ({hi, lo} !== 64'hFFFFFFFF_80000001) begin
      errors++; $display("FAIL ext_max_neg1: got %h_%h expected ffffffff_80000001", hi, lo);
    end
    vectors++;
    if (bus2.mul_q !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL ext_mul_q_hold: got %h expected ffffffff", bus2.mul_q);
    end
    $display("test_extremes: max*-1 -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_start_while_busy();
    int extra = 0;
    bus2.start = 1'b1; bus2.op_a = 32'd7; bus2.op_b = 32'hFFFFFFFD;
    tick();                                   // edge E accepts 7 * -3
    bus2.op_a = 32'd5; bus2.op_b = 32'd5;     // start still high at E+1
    tick();
    bus2.start = 1'b0;
    vectors++;
    if ({bus2.mul_m, bus2.mul_q} !== {32'd7, 32'hFFFFFFFD}) begin
      errors++; $display("FAIL busy_ignore_ops: got %h_%h expected 00000007_fffffffd",
                         bus2.mul_m, bus2.mul_q);
    end
    tick();                                   // E+2 capture
    vectors++;
    if ({bus2.done, bus2.hi_out, bus2.lo_out} !== {1'b1, 64'hFFFFFFFF_FFFFFFEB}) begin
      errors++; $display("FAIL busy_ignore_result: got done=%b %h_%h expected done=1 ffffffff_ffffffeb",
                         bus2.done, bus2.hi_out, bus2.lo_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus2.done || bus2.busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin errors++; $display("FAIL busy_ignore_extra: got %0d active cycles expected 0", extra); end
    $display("test_start_while_busy: second start dropped");
  endtask

  task automatic test_collision();
    bus2.lo_wr = 1'b1; bus2.lo_din = 32'hA5A5A5A5;
    tick();
    bus2.lo_wr = 1'b0;
    vectors++;
    if (bus2.lo_out !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL idle_lo_write: got %h expected a5a5a5a5", bus2.lo_out);
    end
    bus2.start = 1'b1; bus2.op_a = 32'd7; bus2.op_b = 32'hFFFFFFFD;
    tick();                                   // E
    bus2.start = 1'b0;
    bus2.lo_wr = 1'b1; bus2.lo_din = 32'h12345678;
    tick();                                   // E+1: early LO write lands
    bus2.lo_wr = 1'b0;
    vectors++;
    if (bus2.lo_out !== 32'h12345678) begin
      errors++; $display("FAIL settle_lo_write: got %h expected 12345678", bus2.lo_out);
    end
    bus2.hi_wr = 1'b1; bus2.hi_din = 32'hDEADBEEF;
    tick();                                   // E+2: capture + HI write
    bus2.hi_wr = 1'b0;
    vectors++;
    if (bus2.hi_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL collide_hi: got %h expected deadbeef", bus2.hi_out);
    end
    vectors++;
    if (bus2.lo_out !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL collide_lo: got %h expected ffffffeb", bus2.lo_out);
    end
    $display("test_collision: hi=%h lo=%h", bus2.hi_out, bus2.lo_out);
  endtask

  task automatic test_reset_mid_op();
    int act = 0;
    int bn, dn, da;
    logic [31:0] hi, lo;
    bus2.start = 1'b1; bus2.op_a = 32'd7; bus2.op_b = 32'hFFFFFFFD;
    tick();
    bus2.start = 1'b0;
    tick();                                   // in SETTLE, one edge left
    clear = 1'b0;
    #1;
    vectors++;
    if ({bus2.hi_out, bus2.lo_out, bus2.mul_m, bus2.busy} !== 97'h0) begin
      errors++; $display("FAIL async_clear: got hi=%h lo=%h m=%h busy=%b expected all 0",
                         bus2.hi_out, bus2.lo_out, bus2.mul_m, bus2.busy);
    end
    #2;
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus2.done || bus2.busy) act++;
    end
    vectors++;
    if (act !== 0) begin errors++; $display("FAIL abandon_no_done: got %0d active cycles expected 0", act); end
    run_mul2(32'd6, 32'd6, bn, dn, da, hi, lo);
    vectors++;
    if ({dn, hi, lo} !== {32'd1, 32'd0, 32'd36}) begin
      errors++; $display("FAIL post_clear_mul: got done=%0d %h_%h expected done=1 00000000_00000024",
                         dn, hi, lo);
    end
    $display("test_reset_mid_op: 6*6 -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back();
    bus1.start = 1'b1; bus1.op_a = 32'd3; bus1.op_b = 32'd5;
    tick();                                   // E
    bus1.start = 1'b0;
    vectors++;
    if ({bus1.busy, bus1.done} !== 2'b10) begin
      errors++; $display("FAIL b2b_first_busy: got busy,done=%b expected 10", {bus1.busy, bus1.done});
    end
    tick();                                   // E+1 capture 15
    vectors++;
    if ({bus1.done, bus1.busy, bus1.hi_out, bus1.lo_out} !== {2'b10, 32'd0, 32'd15}) begin
      errors++; $display("FAIL b2b_first_done: got done=%b busy=%b %h_%h expected 1 0 00000000_0000000f",
                         bus1.done, bus1.busy, bus1.hi_out, bus1.lo_out);
    end
    bus1.start = 1'b1; bus1.op_a = 32'hFFFFFFFC; bus1.op_b = 32'hFFFFFFFC;
    tick();                                   // E+2 accepts -4 * -4
    bus1.start = 1'b0;
    vectors++;
    if ({bus1.busy, bus1.done, bus1.mul_m} !== {2'b10, 32'hFFFFFFFC}) begin
      errors++; $display("FAIL b2b_accept: got busy=%b done=%b m=%h expected 1 0 fffffffc",
                         bus1.busy, bus1.done, bus1.mul_m);
    end
    tick();                                   // E+3 capture 16
    vectors++;
    if ({bus1.done, bus1.busy, bus1.hi_out, bus1.lo_out} !== {2'b10, 32'd0, 32'd16}) begin
      errors++; $display("FAIL b2b_second_done: got done=%b busy=%b %h_%h expected 1 0 00000000_00000010",
                         bus1.done, bus1.busy, bus1.hi_out, bus1.lo_out);
    end
    tick();
    vectors++;
    if (bus1.done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", bus1.done); end
    $display("test_back_to_back: hi=%h lo=%h", bus1.hi_out, bus1.lo_out);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_start_while_busy();
    test_collision();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
